// File: rtl/bin_to_bcd_4digit_if.sv
// bin_to_bcd_4digit_if
//   Ready/valid bundle for the binary-to-BCD converter.
//   master : producer of `bin` and consumer of `bcd`/`err`.
//            Drives in_valid, bin and out_ready.
//   slave  : the converter itself.
//            Drives in_ready, out_valid, bcd and err.
//   in_valid/in_ready/bin     - input handshake and 14-bit operand
//   out_valid/out_ready/bcd/err - output handshake, packed BCD result, range flag
interface bin_to_bcd_4digit_if;
    logic        in_valid;
    logic        in_ready;
    logic [13:0] bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] bcd;
    logic        err;

    modport master (
        output in_valid, bin, out_ready,
        input  in_ready, out_valid, bcd, err
    );

    modport slave (
        input  in_valid, bin, out_ready,
        output in_ready, out_valid, bcd, err
    );
endinterface

// File: rtl/bin_to_bcd_4digit.sv
// bin_to_bcd_4digit
//   Sequential 14-bit binary to 4-digit packed BCD converter (double dabble,
//   one bit per clock). A value is accepted in IDLE, shifted through 14
//   iterations, and the result is presented in OUT until taken.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - bin_to_bcd_4digit_if.slave (in_valid/in_ready/bin,
//             out_valid/out_ready/bcd/err)
//   Optional feature, macro BIN2BCD_RANGE_CHECK_EN:
//     defined   - inputs above 9999 give err=1 and bcd=16'h9999
//     undefined - err tied 0, bcd is the BCD of (bin mod 10000)
module bin_to_bcd_4digit (
    input logic                clk,
    input logic                rst_n,
    bin_to_bcd_4digit_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    logic [1:0]  state;
    logic [13:0] shift_q;
    logic [15:0] scratch_q;
    logic [3:0]  count_q;
    logic [15:0] bcd_q;
    logic [15:0] adjusted;
    logic [15:0] scratch_next;
`ifdef BIN2BCD_RANGE_CHECK_EN
    logic        range_q;
    logic        err_q;
`endif

    // Add-3 correction on each digit, then shift in the next binary bit.
    // The fifth (ten-thousands) digit only ever receives the carry out of
    // the thousands digit and is never read, so it is dropped by the cast.
    always_comb begin
        adjusted = scratch_q;
        for (int unsigned d = 0; d < 4; d++) begin
            if (scratch_q[d*4 +: 4] >= 4'd5)
                adjusted[d*4 +: 4] = scratch_q[d*4 +: 4] + 4'd3;
        end
        scratch_next = 16'({adjusted, shift_q[13]});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            count_q   <= '0;
            bcd_q     <= '0;
`ifdef BIN2BCD_RANGE_CHECK_EN
            range_q   <= 1'b0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        shift_q   <= bus.bin;
                        scratch_q <= '0;
                        count_q   <= 4'd13;
`ifdef BIN2BCD_RANGE_CHECK_EN
                        range_q   <= (bus.bin > 14'd9999);
`endif
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shift_q   <= {shift_q[12:0], 1'b0};
                    scratch_q <= scratch_next;
                    count_q   <= count_q - 4'd1;
                    if (count_q == 4'd0) begin
`ifdef BIN2BCD_RANGE_CHECK_EN
                        bcd_q <= range_q ? 16'h9999 : scratch_next;
                        err_q <= range_q;
`else
                        bcd_q <= scratch_next;
`endif
                        state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_OUT);
    assign bus.bcd       = bcd_q;
`ifdef BIN2BCD_RANGE_CHECK_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule
